// File: rtl/line_prefetch_pkg.sv
// Shared types for the scanline prefetcher: FSM states, word size, line-buffer address.
package line_prefetch_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} lp_state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 28;
    localparam int LINE_CNT_W = 16;
    localparam int MAX_WORD_W = 10;

    // {bank, word}; word field sized for the longest supported line (1024 words)
    typedef struct packed {
        logic                  bank;
        logic [MAX_WORD_W-1:0] word;
    } buf_addr_t;

endpackage

// File: rtl/lp_addr_gen.sv
// Line/word counters and DDR byte address, built by adding STRIDE per line and 4 per word.
// Latency: address valid the cycle after clr/word_inc/line_inc.
// Backpressure: none; the FSM only steps it when a word or line is finished.
module lp_addr_gen
    import line_prefetch_pkg::*;
#(
    parameter int          LINE_WORDS = 256,
    parameter int          STRIDE     = 1024,
    parameter logic [27:0] BASE_ADDR  = 28'h0,
    localparam int         WW         = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  word_inc,
    input  logic                  line_inc,
    output logic [LINE_CNT_W-1:0] line,
    output logic [WW-1:0]         word,
    output logic                  last_word,
    output logic [ADDR_W-1:0]     addr
);

    logic [ADDR_W-1:0] line_base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line      <= '0;
            word      <= '0;
            line_base <= BASE_ADDR;
            addr      <= BASE_ADDR;
        end else if (clr) begin
            line      <= '0;
            word      <= '0;
            line_base <= BASE_ADDR;
            addr      <= BASE_ADDR;
        end else if (line_inc) begin
            line      <= line + LINE_CNT_W'(1);
            word      <= '0;
            line_base <= line_base + ADDR_W'(STRIDE);
            addr      <= line_base + ADDR_W'(STRIDE);
        end else if (word_inc) begin
            word <= word + WW'(1);
            addr <= addr + ADDR_W'(WORD_BYTES);
        end
    end

    assign last_word = (word == WW'(LINE_WORDS - 1));

endmodule

// File: rtl/ddr_line_prefetch.sv
// Prefetches the next scanline from DDR into the idle bank of a two-bank line buffer.
// Latency: 2 cycles + DDR latency per word; buf_wr one cycle after ddr_ready.
// Backpressure: one outstanding request; line_done while busy is held as a single pending fetch.
// LINE_PREFETCH_STATS_EN adds underrun_cnt and last_lat outputs.
module ddr_line_prefetch
    import line_prefetch_pkg::*;
#(
    parameter int          LINE_WORDS = 256,
    parameter int          LINES      = 224,
    parameter int          STRIDE     = 1024,
    parameter logic [27:0] BASE_ADDR  = 28'h0,
    localparam int         WW         = $clog2(LINE_WORDS)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        line_done,
    output logic [27:0] ddr_addr,
    output logic        ddr_req,
    input  logic        ddr_ready,
    input  logic [31:0] ddr_dout,
    output logic        buf_wr,
    output logic [WW:0] buf_waddr,
    output logic [31:0] buf_wdata,
    output logic        bank_rd,
    output logic        busy,
    output logic        underrun
`ifdef LINE_PREFETCH_STATS_EN
    ,
    output logic [15:0] underrun_cnt,
    output logic [15:0] last_lat
`endif
);

    lp_state_t             state;
    logic                  pending;
    logic                  pend_bank;
    logic                  fetch_bank;
    logic [LINE_CNT_W-1:0] line;
    logic [LINE_CNT_W-1:0] eff_line;
    logic [WW-1:0]         word;
    logic                  last_word;
    logic [ADDR_W-1:0]     gen_addr;
    logic                  ld, launch, pend_set, und_evt, word_inc, line_inc, bank_base;
    buf_addr_t             wa;

    lp_addr_gen #(
        .LINE_WORDS (LINE_WORDS),
        .STRIDE     (STRIDE),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (frame_start),
        .word_inc  (word_inc),
        .line_inc  (line_inc),
        .line      (line),
        .word      (word),
        .last_word (last_word),
        .addr      (gen_addr)
    );

    assign ld       = line_done && !frame_start;
    assign launch   = pending && (state == IDLE || state == DONE);
    // Line a new line_done would fetch, counting the active and the queued fetch ahead of it
    assign eff_line = line + LINE_CNT_W'(state != IDLE) + LINE_CNT_W'(pending);
    assign pend_set = ld && (eff_line < LINE_CNT_W'(LINES)) && !(pending && !launch);
    assign und_evt  = ld && busy;
    assign word_inc = (state == WAIT) && ddr_ready && !last_word && !frame_start;
    assign line_inc = (state == DONE) && !frame_start;
    // Completing line 0 hands it to the pixel side
    assign bank_base = (state == DONE && line == '0) ? 1'b0 : bank_rd;

    always_comb begin
        wa      = '0;
        wa.bank = fetch_bank;
        wa.word = MAX_WORD_W'(word);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= 1'b0;
            pend_bank  <= 1'b0;
            fetch_bank <= 1'b0;
            ddr_addr   <= '0;
            ddr_req    <= 1'b0;
            buf_wr     <= 1'b0;
            buf_waddr  <= '0;
            buf_wdata  <= '0;
            bank_rd    <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            ddr_req <= 1'b0;
            buf_wr  <= 1'b0;
            if (frame_start) begin
                pending   <= 1'b1;
                pend_bank <= 1'b0;
                bank_rd   <= 1'b1;
                underrun  <= 1'b0;
                if ((state == WAIT || state == DRAIN) && !ddr_ready) begin
                    state <= DRAIN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                bank_rd <= ld ? ~bank_base : bank_base;
                if (und_evt) underrun <= 1'b1;
                if (pend_set) begin
                    pending   <= 1'b1;
                    pend_bank <= ~bank_base;
                end else if (launch) begin
                    pending <= 1'b0;
                end
                case (state)
                    IDLE, DONE: begin
                        if (pending) begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            fetch_bank <= pend_bank;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ISSUE: begin
                        ddr_req  <= 1'b1;
                        ddr_addr <= gen_addr;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (ddr_ready) begin
                            buf_wr    <= 1'b1;
                            buf_waddr <= {wa.bank, wa.word[WW-1:0]};
                            buf_wdata <= ddr_dout;
                            if (last_word) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end else begin
                                state <= ISSUE;
                            end
                        end
                    end
                    DRAIN: begin
                        if (ddr_ready) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LINE_PREFETCH_STATS_EN
    logic [15:0] lat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= '0;
            last_lat     <= '0;
            lat_cnt      <= '0;
        end else begin
            if (und_evt && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            // Zero in the cycle the line's first ddr_req is visible
            if (state == ISSUE && word == '0) lat_cnt <= '0;
            else if (lat_cnt != 16'hFFFF)     lat_cnt <= lat_cnt + 16'd1;
            if (state == DONE && !frame_start) last_lat <= lat_cnt;
        end
    end
`endif

endmodule
